// File: rtl/wx_read_seq.sv
// wx_read_seq: streams bit pairs from weight/input memories and reports XNOR popcount and sign.
module wx_read_seq #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int SEL_LEN    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [X_ADDR_LEN-1:0] len,
  input  logic [W_ADDR_LEN-1:0] w_base,
  input  logic [SEL_LEN-1:0]    w_sel_in,
  input  logic [SEL_LEN-1:0]    x_sel_in,
  input  logic                  w_data,
  input  logic                  x_data,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic [SEL_LEN-1:0]    w_sel,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic [SEL_LEN-1:0]    x_sel,
  output logic                  w_wq,
  output logic                  x_wq,
  output logic                  busy,
  output logic                  done,
  output logic [X_ADDR_LEN:0]   popcount,
  output logic                  sign_out
);
  typedef enum logic [1:0] {IDLE, READ, LAST, DONE} state_t;
  state_t                  state_q, state_d;
  logic [X_ADDR_LEN-1:0]   k_q, k_d, len_q, len_d;
  logic [W_ADDR_LEN-1:0]   w_base_q, w_base_d;
  logic [SEL_LEN-1:0]      w_sel_q, w_sel_d, x_sel_q, x_sel_d;
  logic [X_ADDR_LEN:0]     acc_q, acc_d, acc_inc;
  logic                    sign_q, sign_d, addr_on;
  assign acc_inc = acc_q + {{X_ADDR_LEN{1'b0}}, ~(w_data ^ x_data)};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      len_q    <= '0;
      w_base_q <= '0;
      w_sel_q  <= '0;
      x_sel_q  <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      len_q    <= len_d;
      w_base_q <= w_base_d;
      w_sel_q  <= w_sel_d;
      x_sel_q  <= x_sel_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    w_base_d = w_base_q;
    w_sel_d  = w_sel_q;
    x_sel_d  = x_sel_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = (len == '0) ? DONE : READ;
        k_d      = '0;
        len_d    = len;
        w_base_d = w_base;
        w_sel_d  = w_sel_in;
        x_sel_d  = x_sel_in;
        acc_d    = '0;
        sign_d   = (len == '0);
      end
      READ: begin
        // data returning now belongs to address k-1, so nothing to add on k=0
        acc_d   = (k_q != '0) ? acc_inc : acc_q;
        state_d = (k_q == len_q - X_ADDR_LEN'(1)) ? LAST : READ;
        k_d     = (k_q == len_q - X_ADDR_LEN'(1)) ? k_q : k_q + X_ADDR_LEN'(1);
      end
      LAST: begin
        acc_d   = acc_inc;
        sign_d  = {acc_inc, 1'b0} >= {2'b00, len_q};
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy     = state_q != IDLE;
    done     = state_q == DONE;
    addr_on  = (state_q == READ) || (state_q == LAST);
    w_addr   = addr_on ? w_base_q + W_ADDR_LEN'(k_q) : '0;
    x_addr   = addr_on ? k_q : '0;
    w_sel    = busy ? w_sel_q : '0;
    x_sel    = busy ? x_sel_q : '0;
    w_wq     = 1'b0;
    x_wq     = 1'b0;
    popcount = acc_q;
    sign_out = sign_q;
  end
endmodule
